pattern_gen_multi: RTL and testbench

PATTERN_GEN_MULTI -- requirements
Module: pattern_gen_multi

---
 rtl/pattern_gen_multi.sv | 199 +++++++++++++++++++
 tb/tb_pattern_gen_multi.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_gen_multi.sv
// Multi-mode video test pattern generator: border/box, colour bars, grey ramp,
// checkerboard and solid fills. Define PATTERN_GEN_ANIM_EN to make the box bounce.
module pattern_gen_multi #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 600,
    parameter int XY_W     = 10,
    parameter int COLOR_W  = 8,
    parameter int BORDER   = 20,
    parameter int BOX_HALF = 10,
    parameter int STEP     = 2
) (
    input  logic               pixelClk,
    input  logic               rstN,
    input  logic               vs,
    input  logic               de,
    input  logic [XY_W-1:0]    pixelsX,
    input  logic [XY_W-1:0]    pixelsY,
    input  logic [2:0]         mode,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b,
    output logic               frameStart
);

    localparam int DW    = XY_W + 2;
    localparam int SUM_W = XY_W + COLOR_W + 8;

    localparam logic [XY_W-1:0] X_LEFT    = XY_W'(BORDER);
    localparam logic [XY_W-1:0] X_RIGHT   = XY_W'(H_ACTIVE - BORDER);
    localparam logic [XY_W-1:0] Y_TOP     = XY_W'(BORDER);
    localparam logic [XY_W-1:0] Y_BOT     = XY_W'(V_ACTIVE - BORDER);
    localparam logic [XY_W-1:0] BAR_WIDTH = XY_W'(H_ACTIVE / 8);
    localparam logic [XY_W-1:0] BAR_COUNT = XY_W'(8);
    localparam logic [XY_W-1:0] X_CENTER  = XY_W'(H_ACTIVE / 2);
    localparam logic [XY_W-1:0] Y_CENTER  = XY_W'(V_ACTIVE / 2);
    localparam logic signed [DW-1:0] HALF = DW'(BOX_HALF);
    localparam logic [7:0] BG_BYTE = 8'h20;

    // Background level: the 0x20 byte pattern repeated to fill the channel width.
    function automatic logic [COLOR_W-1:0] bg_level();
        logic [COLOR_W-1:0] v;
        v = '0;
        for (int i = 0; i < COLOR_W; i++) begin
            v[i] = BG_BYTE[i % 8];
        end
        return v;
    endfunction

    localparam logic [COLOR_W-1:0] BG = bg_level();

    logic               last_vs;
    logic               vs_armed;
    logic               frame_event;
    logic [2:0]         active_mode;
    logic [7:0]         frame_count;
    logic [XY_W-1:0]    box_x;
    logic [XY_W-1:0]    box_y;

    // An edge only counts once vs has been seen low since reset, so a vs that is
    // already high when reset lifts does not fake a frame start.
    assign frame_event = vs_armed && !last_vs && vs;

    always_ff @(posedge pixelClk or negedge rstN) begin
        if (!rstN) begin
            last_vs     <= 1'b0;
            vs_armed    <= 1'b0;
            active_mode <= 3'd0;
            frame_count <= 8'd0;
        end else begin
            last_vs  <= vs;
            vs_armed <= vs_armed | ~vs;
            if (frame_event) begin
                active_mode <= mode;
                frame_count <= frame_count + 8'd1;
            end
        end
    end

`ifdef PATTERN_GEN_ANIM_EN
    logic dir_x;
    logic dir_y;

    // Returns {new_dir, new_pos}; dir 1 means moving toward larger coordinates.
    function automatic logic [XY_W:0] step_axis(input logic [XY_W-1:0] pos,
                                                input logic dir, input int active);
        int p;
        p = int'(pos);
        if (dir) begin
            if (p + BOX_HALF + STEP > active - BORDER - 1)
                return {1'b0, XY_W'(p - STEP)};
            else
                return {1'b1, XY_W'(p + STEP)};
        end else begin
            if (p - BOX_HALF - STEP < BORDER)
                return {1'b1, XY_W'(p + STEP)};
            else
                return {1'b0, XY_W'(p - STEP)};
        end
    endfunction

    always_ff @(posedge pixelClk or negedge rstN) begin
        if (!rstN) begin
            box_x <= X_CENTER;
            box_y <= Y_CENTER;
            dir_x <= 1'b1;
            dir_y <= 1'b1;
        end else if (frame_event) begin
            {dir_x, box_x} <= step_axis(box_x, dir_x, H_ACTIVE);
            {dir_y, box_y} <= step_axis(box_y, dir_y, V_ACTIVE);
        end
    end
`else
    assign box_x = X_CENTER;
    assign box_y = Y_CENTER;
`endif

    logic signed [DW-1:0] dx;
    logic signed [DW-1:0] dy;
    logic                 in_box;
    logic [XY_W-1:0]      bar_idx;
    logic [SUM_W-1:0]     ramp_sum;
    logic [COLOR_W-1:0]   ramp;
    logic [COLOR_W-1:0]   next_r;
    logic [COLOR_W-1:0]   next_g;
    logic [COLOR_W-1:0]   next_b;

    assign dx       = $signed({2'b00, pixelsX}) - $signed({2'b00, box_x});
    assign dy       = $signed({2'b00, pixelsY}) - $signed({2'b00, box_y});
    assign in_box   = (dx <= HALF) && (dx >= -HALF) && (dy <= HALF) && (dy >= -HALF);
    assign bar_idx  = pixelsX / BAR_WIDTH;
    assign ramp_sum = SUM_W'(pixelsX) + SUM_W'(frame_count);
    assign ramp     = ramp_sum[COLOR_W-1:0];

    // Pattern selection; all patterns are pure functions of the current pixel
    // and the per-frame state latched at frame start.
    always_comb begin
        next_r = '0;
        next_g = '0;
        next_b = '0;
        if (de) begin
            case (active_mode)
                3'd0: begin
                    if (in_box) begin
                        next_r = '1; next_g = '1; next_b = '1;
                    end else if (pixelsY < Y_TOP || pixelsY >= Y_BOT) begin
                        next_b = '1;
                    end else if (pixelsX < X_LEFT) begin
                        next_r = '1;
                    end else if (pixelsX >= X_RIGHT) begin
                        next_g = '1;
                    end else begin
                        next_r = BG; next_g = BG; next_b = BG;
                    end
                end
                3'd1: begin
                    if (bar_idx < BAR_COUNT) begin
                        case (bar_idx[2:0])
                            3'd0: begin next_r = '1; next_g = '1; next_b = '1; end
                            3'd1: begin next_r = '1; next_g = '1; end
                            3'd2: begin next_g = '1; next_b = '1; end
                            3'd3: begin next_g = '1; end
                            3'd4: begin next_r = '1; next_b = '1; end
                            3'd5: begin next_r = '1; end
                            3'd6: begin next_b = '1; end
                            default: ;
                        endcase
                    end
                end
                3'd2: begin
                    next_r = ramp; next_g = ramp; next_b = ramp;
                end
                3'd3: begin
                    if (pixelsX[5] ^ pixelsY[5]) begin
                        next_r = '1; next_g = '1; next_b = '1;
                    end
                end
                3'd4: begin next_r = '1; next_g = '1; next_b = '1; end
                3'd5: begin next_r = '1; end
                3'd6: begin next_g = '1; end
                default: begin next_b = '1; end
            endcase
        end
    end

    always_ff @(posedge pixelClk or negedge rstN) begin
        if (!rstN) begin
            r          <= '0;
            g          <= '0;
            b          <= '0;
            frameStart <= 1'b0;
        end else begin
            r          <= next_r;
            g          <= next_g;
            b          <= next_b;
            frameStart <= frame_event;
        end
    end

endmodule

// File: tb/tb_pattern_gen_multi.sv
// Bench for pattern_gen_multi: reference model plus directed vectors with literal expectations.
module tb_pattern_gen_multi;

    localparam int H   = 800;
    localparam int V   = 600;
    localparam int BRD = 20;
    localparam int BH  = 10;
    localparam int STP = 2;

    logic       pixelClk = 1'b0;
    logic       rstN     = 1'b0;
    logic       vs       = 1'b0;
    logic       de       = 1'b0;
    logic [9:0] pixelsX  = '0;
    logic [9:0] pixelsY  = '0;
    logic [2:0] mode     = '0;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       frameStart;

    pattern_gen_multi dut (
        .pixelClk  (pixelClk),
        .rstN      (rstN),
        .vs        (vs),
        .de        (de),
        .pixelsX   (pixelsX),
        .pixelsY   (pixelsY),
        .mode      (mode),
        .r         (r),
        .g         (g),
        .b         (b),
        .frameStart(frameStart)
    );

    always #5 pixelClk = ~pixelClk;

    int vectors     = 0;
    int miscompares = 0;
    int fs_count    = 0;

    int m_mode  = 0;
    int m_fc    = 0;
    int m_bx    = H / 2;
    int m_by    = V / 2;
    int m_dx    = 1;
    int m_dy    = 1;
    bit m_last  = 1'b0;
    bit m_armed = 1'b0;

    // Colour a pixel straight from the pattern definitions.
    function automatic logic [23:0] model_rgb(bit en, int md, int x, int y, int fc, int bx, int by);
        logic [23:0] bars [8];
        logic [7:0]  v;
        int          bar;
        bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
        bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
        if (!en) return 24'h000000;
        case (md)
            0: begin
                if (x - bx <= BH && bx - x <= BH && y - by <= BH && by - y <= BH) return 24'hFFFFFF;
                if (y < BRD || y >= V - BRD) return 24'h0000FF;
                if (x < BRD) return 24'hFF0000;
                if (x >= H - BRD) return 24'h00FF00;
                return 24'h202020;
            end
            1: begin
                bar = x / (H / 8);
                if (bar > 7) return 24'h000000;
                return bars[bar];
            end
            2: begin
                v = 8'((x + fc) % 256);
                return {v, v, v};
            end
            3: return (((x / 32) ^ (y / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
            4: return 24'hFFFFFF;
            5: return 24'hFF0000;
            6: return 24'h00FF00;
            default: return 24'h0000FF;
        endcase
    endfunction

    task automatic axis_step(inout int p, inout int d, input int active);
        if (d == 1 && p + BH + STP > active - BRD - 1) begin d = -1; p = p - STP; end
        else if (d == -1 && p - BH - STP < BRD) begin d = 1; p = p + STP; end
        else p = p + d * STP;
    endtask

    // Per-cycle reference comparison of colour and frameStart.
    always @(posedge pixelClk or negedge rstN) begin : compare_proc
        logic [23:0] exp_rgb;
        logic        exp_fs;
        bit          evt;
        if (!rstN) begin
            m_mode = 0; m_fc = 0; m_bx = H / 2; m_by = V / 2; m_dx = 1; m_dy = 1;
            m_last = 1'b0; m_armed = 1'b0;
            exp_rgb = 24'h0; exp_fs = 1'b0;
        end else begin
            exp_rgb = model_rgb(de, m_mode, int'(pixelsX), int'(pixelsY), m_fc, m_bx, m_by);
            evt     = m_armed && !m_last && vs;
            exp_fs  = evt;
            if (!vs) m_armed = 1'b1;
            m_last = vs;
            if (evt) begin
                m_mode = int'(mode);
                m_fc   = (m_fc + 1) % 256;
`ifdef PATTERN_GEN_ANIM_EN
                axis_step(m_bx, m_dx, H);
                axis_step(m_by, m_dy, V);
`endif
            end
        end
        #1;
        vectors++;
        if ({r, g, b, frameStart} !== {exp_rgb, exp_fs}) begin
            miscompares++;
            $display("[TB] FAIL model t=%0t: got rgb=%h fs=%b, expected rgb=%h fs=%b",
                     $time, {r, g, b}, frameStart, exp_rgb, exp_fs);
        end
    end

    always @(negedge pixelClk) begin
        if (frameStart === 1'b1) fs_count++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input bit en, input int x, input int y);
        @(negedge pixelClk);
        de      = en;
        pixelsX = 10'(x);
        pixelsY = 10'(y);
    endtask

    task automatic checkOutput(input string name, input logic [23:0] exp_rgb);
        @(posedge pixelClk);
        #1;
        vectors++;
        if ({r, g, b} !== exp_rgb) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, {r, g, b}, exp_rgb);
        end
    endtask

    task automatic checkCount(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic frameTick();
        @(negedge pixelClk);
        vs = 1'b1;
        @(negedge pixelClk);
        @(negedge pixelClk);
        vs = 1'b0;
        @(negedge pixelClk);
    endtask

    initial begin
        int c0;
        int c1;
        $display("[TB] start");
        repeat (3) @(negedge pixelClk);
        checkOutput("reset_rgb", 24'h000000);
        checkCount("reset_fs", int'(frameStart), 0);
        @(negedge pixelClk);
        rstN = 1'b1;
        @(negedge pixelClk);

        frameTick();
        applyStimulus(1'b1, 0, 100);   checkOutput("m0_left_bar", 24'hFF0000);
        applyStimulus(1'b1, 400, 300); checkOutput("m0_box", 24'hFFFFFF);
        applyStimulus(1'b1, 100, 100); checkOutput("m0_bg", 24'h202020);
        applyStimulus(1'b0, 100, 100); checkOutput("m0_de_off", 24'h000000);

        @(negedge pixelClk);
        mode = 3'd1;
        applyStimulus(1'b1, 150, 100); checkOutput("mode_ignored_midframe", 24'h202020);
        frameTick();
        applyStimulus(1'b1, 150, 100); checkOutput("m1_yellow", 24'hFFFF00);
        applyStimulus(1'b1, 799, 100); checkOutput("m1_last_bar", 24'h000000);
        applyStimulus(1'b1, 850, 100); checkOutput("m1_beyond", 24'h000000);

        mode = 3'd2;
        frameTick();
        applyStimulus(1'b1, 10, 50);  checkOutput("m2_ramp10", 24'h0D0D0D);
        applyStimulus(1'b1, 253, 50); checkOutput("m2_ramp_wrap", 24'h000000);

        mode = 3'd3;
        c0 = fs_count;
        repeat (5) frameTick();
        checkCount("five_pulses", fs_count - c0, 5);
        applyStimulus(1'b1, 32, 0);  checkOutput("m3_white", 24'hFFFFFF);
        applyStimulus(1'b1, 32, 32); checkOutput("m3_black", 24'h000000);
        c0 = fs_count;
        @(negedge pixelClk);
        vs = 1'b1;
        repeat (3) @(negedge pixelClk);
        c1 = fs_count;
        repeat (100) @(negedge pixelClk);
        checkCount("vs_high_one_pulse", c1 - c0, 1);
        checkCount("vs_high_no_extra", fs_count, c1);
        vs = 1'b0;
        @(negedge pixelClk);

        for (int m = 4; m < 8; m++) begin
            mode = 3'(m);
            frameTick();
            applyStimulus(1'b1, 200, 200);
            checkOutput("solid", model_rgb(1'b1, m, 200, 200, 0, 0, 0));
        end

        mode = 3'd0;
        repeat (185) frameTick();
`ifdef PATTERN_GEN_ANIM_EN
        applyStimulus(1'b1, 740, 440); checkOutput("anim_box_center", 24'hFFFFFF);
        applyStimulus(1'b1, 730, 440); checkOutput("anim_box_edge", 24'hFFFFFF);
        applyStimulus(1'b1, 751, 440); checkOutput("anim_box_outside", 24'h202020);
`else
        applyStimulus(1'b1, 400, 300); checkOutput("fixed_box_center", 24'hFFFFFF);
        applyStimulus(1'b1, 410, 310); checkOutput("fixed_box_corner", 24'hFFFFFF);
        applyStimulus(1'b1, 390, 290); checkOutput("fixed_box_corner2", 24'hFFFFFF);
        applyStimulus(1'b1, 411, 300); checkOutput("fixed_box_outside", 24'h202020);
        applyStimulus(1'b1, 389, 300); checkOutput("fixed_box_outside2", 24'h202020);
`endif

        mode = 3'd4;
        frameTick();
        applyStimulus(1'b1, 200, 200); checkOutput("pre_reset_white", 24'hFFFFFF);
        @(posedge pixelClk);
        #3 rstN = 1'b0;
        #1;
        vectors++;
        if ({r, g, b} !== 24'h000000) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got %h, expected 000000", {r, g, b});
        end
        @(negedge pixelClk);
        vs   = 1'b1;
        mode = 3'd2;
        repeat (2) @(negedge pixelClk);
        rstN = 1'b1;
        c0 = fs_count;
        repeat (5) @(negedge pixelClk);
        checkCount("no_event_vs_high_at_reset", fs_count, c0);
        applyStimulus(1'b1, 0, 100); checkOutput("mode_reset_to_0", 24'hFF0000);
        @(negedge pixelClk);
        vs = 1'b0;
        @(negedge pixelClk);
        frameTick();
        applyStimulus(1'b1, 10, 100); checkOutput("count_reset_to_0", 24'h0B0B0B);
        applyStimulus(1'b0, 0, 0);
        repeat (2) @(negedge pixelClk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
